ctrl_pipe: RTL and testbench

Parametrised, registered successor to the combinational instruction decoder. Decodes the full RV32I integer set: R, I-ALU, load, store, all six branches, JAL, JALR, LUI, AUIPC. Sits between the fetch and execute stages with valid/ready handshakes on both sides, a flush input, a load-use interlock, and illegal-instruction flagging.

---
 rtl/ctrl_pipe_pkg.sv | 62 ++++++
 rtl/ctrl_pipe_dec.sv | 164 ++++++++++++++++
 rtl/ctrl_pipe.sv | 164 ++++++++++++++++
 tb/tb_ctrl_pipe.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pipe_pkg.sv
// Shared encodings for the registered RV32I control decoder: ALU opcodes,
// ALU operand selects, immediate formats and the base opcode map.
package ctrl_pipe_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } alu_op_e;

  typedef enum logic [1:0] {
    ALU_SRC_REG     = 2'd0,
    ALU_SRC_IMM     = 2'd1,
    ALU_SRC_FOUR_PC = 2'd2,
    ALU_SRC_PC_IMM  = 2'd3
  } alu_src_e;

  typedef enum logic [2:0] {
    IMM_GEN_I = 3'd0,
    IMM_GEN_S = 3'd1,
    IMM_GEN_B = 3'd2,
    IMM_GEN_U = 3'd3,
    IMM_GEN_J = 3'd4
  } imm_gen_e;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [6:0] F7_BASE = 7'h00;
  localparam logic [6:0] F7_ALT  = 7'h20;

  // funct3 to ALU operation; alt selects SUB/SRA over ADD/SRL.
  function automatic logic [3:0] alu_from_f3(input logic [2:0] f3, input logic alt);
    logic [3:0] op;
    case (f3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/ctrl_pipe_dec.sv
// Combinational RV32I control decoder. Produces the control bundle for one
// instruction plus which source registers it actually reads.
module ctrl_dec
  import ctrl_pipe_pkg::*;
#(
  parameter int CPU_WIDTH      = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int ALU_OP_WIDTH   = 4
) (
  input  logic [CPU_WIDTH-1:0]      inst_i,
  output logic                      branch_o,
  output logic [2:0]                branch_cond_o,
  output logic                      jump_o,
  output logic                      jalr_o,
  output logic                      reg_wen_o,
  output logic [REG_ADDR_WIDTH-1:0] reg_waddr_o,
  output logic [REG_ADDR_WIDTH-1:0] reg1_raddr_o,
  output logic [REG_ADDR_WIDTH-1:0] reg2_raddr_o,
  output logic [2:0]                imm_gen_op_o,
  output logic [ALU_OP_WIDTH-1:0]   alu_op_o,
  output logic [1:0]                alu_src_sel_o,
  output logic                      mem_ren_o,
  output logic                      mem_wen_o,
  output logic [2:0]                mem_size_o,
  output logic                      illegal_o,
  output logic                      rs1_used_o,
  output logic                      rs2_used_o
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [4:0] rd;
  logic [4:0] rs1;
  logic [4:0] rs2;
  logic       legal;
  logic       uses_rd;
  logic [3:0] alu_code;

  assign opcode = inst_i[6:0];
  assign rd     = inst_i[11:7];
  assign funct3 = inst_i[14:12];
  assign rs1    = inst_i[19:15];
  assign rs2    = inst_i[24:20];
  assign funct7 = inst_i[31:25];

  // Classify the opcode and fill the bundle; undecodable words collapse to a side-effect-free no-op.
  always_comb begin
    legal         = 1'b1;
    uses_rd       = 1'b0;
    rs1_used_o    = 1'b0;
    rs2_used_o    = 1'b0;
    branch_o      = 1'b0;
    branch_cond_o = 3'b000;
    jump_o        = 1'b0;
    jalr_o        = 1'b0;
    imm_gen_op_o  = IMM_GEN_I;
    alu_code      = ALU_AND;
    alu_src_sel_o = ALU_SRC_REG;
    mem_ren_o     = 1'b0;
    mem_wen_o     = 1'b0;
    mem_size_o    = 3'b000;
    case (opcode)
      OPC_OP: begin
        legal      = (funct7 == F7_BASE) ||
                     (funct7 == F7_ALT && (funct3 == 3'b000 || funct3 == 3'b101));
        alu_code   = alu_from_f3(funct3, funct7 == F7_ALT);
        uses_rd    = 1'b1;
        rs1_used_o = 1'b1;
        rs2_used_o = 1'b1;
      end
      OPC_OP_IMM: begin
        case (funct3)
          3'b001:  legal = (funct7 == F7_BASE);
          3'b101:  legal = (funct7 == F7_BASE) || (funct7 == F7_ALT);
          default: legal = 1'b1;
        endcase
        alu_code      = alu_from_f3(funct3, funct3 == 3'b101 && funct7 == F7_ALT);
        alu_src_sel_o = ALU_SRC_IMM;
        uses_rd       = 1'b1;
        rs1_used_o    = 1'b1;
      end
      OPC_LOAD: begin
        legal         = (funct3 != 3'b011) && (funct3 != 3'b110) && (funct3 != 3'b111);
        alu_code      = ALU_ADD;
        alu_src_sel_o = ALU_SRC_IMM;
        mem_ren_o     = 1'b1;
        mem_size_o    = funct3;
        uses_rd       = 1'b1;
        rs1_used_o    = 1'b1;
      end
      OPC_STORE: begin
        legal         = (funct3[2] == 1'b0) && (funct3[1:0] != 2'b11);
        imm_gen_op_o  = IMM_GEN_S;
        alu_code      = ALU_ADD;
        alu_src_sel_o = ALU_SRC_IMM;
        mem_wen_o     = 1'b1;
        mem_size_o    = funct3;
        rs1_used_o    = 1'b1;
        rs2_used_o    = 1'b1;
      end
      OPC_BRANCH: begin
        legal         = (funct3[2:1] != 2'b01);
        branch_o      = 1'b1;
        branch_cond_o = funct3;
        imm_gen_op_o  = IMM_GEN_B;
        alu_code      = ALU_SUB;
        rs1_used_o    = 1'b1;
        rs2_used_o    = 1'b1;
      end
      OPC_JAL: begin
        jump_o        = 1'b1;
        imm_gen_op_o  = IMM_GEN_J;
        alu_code      = ALU_ADD;
        alu_src_sel_o = ALU_SRC_FOUR_PC;
        uses_rd       = 1'b1;
      end
      OPC_JALR: begin
        legal         = (funct3 == 3'b000);
        jump_o        = 1'b1;
        jalr_o        = 1'b1;
        alu_code      = ALU_ADD;
        alu_src_sel_o = ALU_SRC_FOUR_PC;
        uses_rd       = 1'b1;
        rs1_used_o    = 1'b1;
      end
      OPC_LUI: begin
        imm_gen_op_o  = IMM_GEN_U;
        alu_code      = ALU_ADD;
        alu_src_sel_o = ALU_SRC_IMM;
        uses_rd       = 1'b1;
      end
      OPC_AUIPC: begin
        imm_gen_op_o  = IMM_GEN_U;
        alu_code      = ALU_ADD;
        alu_src_sel_o = ALU_SRC_PC_IMM;
        uses_rd       = 1'b1;
      end
      default: legal = 1'b0;
    endcase
    if (!legal) begin
      uses_rd       = 1'b0;
      rs1_used_o    = 1'b0;
      rs2_used_o    = 1'b0;
      branch_o      = 1'b0;
      branch_cond_o = 3'b000;
      jump_o        = 1'b0;
      jalr_o        = 1'b0;
      imm_gen_op_o  = IMM_GEN_I;
      alu_code      = ALU_AND;
      alu_src_sel_o = ALU_SRC_REG;
      mem_ren_o     = 1'b0;
      mem_wen_o     = 1'b0;
      mem_size_o    = 3'b000;
    end
    illegal_o    = !legal;
    reg_wen_o    = uses_rd;
    reg_waddr_o  = uses_rd ? REG_ADDR_WIDTH'(rd) : '0;
    reg1_raddr_o = rs1_used_o ? REG_ADDR_WIDTH'(rs1) : '0;
    reg2_raddr_o = rs2_used_o ? REG_ADDR_WIDTH'(rs2) : '0;
    alu_op_o     = ALU_OP_WIDTH'(alu_code);
  end

endmodule

// File: rtl/ctrl_pipe.sv
// Registered control stage between fetch and execute: one-deep output
// register with valid/ready on both sides, flush, and a load-use interlock
// that holds back consumers of a load's destination for a few cycles.
module ctrl_pipe
  import ctrl_pipe_pkg::*;
#(
  parameter int CPU_WIDTH      = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int ALU_OP_WIDTH   = 4,
  parameter int LOAD_USE_STALL = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [CPU_WIDTH-1:0]      inst,
  input  logic [CPU_WIDTH-1:0]      pc,
  input  logic                      flush,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [CPU_WIDTH-1:0]      out_pc,
  output logic                      branch,
  output logic [2:0]                branch_cond,
  output logic                      jump,
  output logic                      jalr,
  output logic                      reg_wen,
  output logic [REG_ADDR_WIDTH-1:0] reg_waddr,
  output logic [REG_ADDR_WIDTH-1:0] reg1_raddr,
  output logic [REG_ADDR_WIDTH-1:0] reg2_raddr,
  output logic [2:0]                imm_gen_op,
  output logic [ALU_OP_WIDTH-1:0]   alu_op,
  output logic [1:0]                alu_src_sel,
  output logic                      mem_ren,
  output logic                      mem_wen,
  output logic [2:0]                mem_size,
  output logic                      illegal
);

  localparam logic [1:0] STALL_INIT = 2'(LOAD_USE_STALL);

  typedef struct packed {
    logic                      branch;
    logic [2:0]                branch_cond;
    logic                      jump;
    logic                      jalr;
    logic                      reg_wen;
    logic [REG_ADDR_WIDTH-1:0] reg_waddr;
    logic [REG_ADDR_WIDTH-1:0] reg1_raddr;
    logic [REG_ADDR_WIDTH-1:0] reg2_raddr;
    logic [2:0]                imm_gen_op;
    logic [ALU_OP_WIDTH-1:0]   alu_op;
    logic [1:0]                alu_src_sel;
    logic                      mem_ren;
    logic                      mem_wen;
    logic [2:0]                mem_size;
    logic                      illegal;
  } bundle_t;

  bundle_t                   bundle_d;
  bundle_t                   bundle_q;
  logic [CPU_WIDTH-1:0]      out_pc_q;
  logic                      out_valid_q;
  logic [1:0]                stall_cnt_q;
  logic [REG_ADDR_WIDTH-1:0] ld_rd_q;
  logic                      rs1_used;
  logic                      rs2_used;
  logic                      hazard;
  logic                      take;
  logic                      arm;

  ctrl_dec #(
    .CPU_WIDTH     (CPU_WIDTH),
    .REG_ADDR_WIDTH(REG_ADDR_WIDTH),
    .ALU_OP_WIDTH  (ALU_OP_WIDTH)
  ) u_dec (
    .inst_i       (inst),
    .branch_o     (bundle_d.branch),
    .branch_cond_o(bundle_d.branch_cond),
    .jump_o       (bundle_d.jump),
    .jalr_o       (bundle_d.jalr),
    .reg_wen_o    (bundle_d.reg_wen),
    .reg_waddr_o  (bundle_d.reg_waddr),
    .reg1_raddr_o (bundle_d.reg1_raddr),
    .reg2_raddr_o (bundle_d.reg2_raddr),
    .imm_gen_op_o (bundle_d.imm_gen_op),
    .alu_op_o     (bundle_d.alu_op),
    .alu_src_sel_o(bundle_d.alu_src_sel),
    .mem_ren_o    (bundle_d.mem_ren),
    .mem_wen_o    (bundle_d.mem_wen),
    .mem_size_o   (bundle_d.mem_size),
    .illegal_o    (bundle_d.illegal),
    .rs1_used_o   (rs1_used),
    .rs2_used_o   (rs2_used)
  );

  // Unused source fields decode to 0 and are gated by rs*_used, so x0 never matches an armed ld_rd.
  assign hazard   = (stall_cnt_q != 2'd0) && in_valid &&
                    ((rs1_used && bundle_d.reg1_raddr == ld_rd_q) ||
                     (rs2_used && bundle_d.reg2_raddr == ld_rd_q));
  assign in_ready = (!out_valid_q || out_ready) && !hazard && !flush;
  assign take     = in_valid && in_ready && !rst;
  assign arm      = out_valid_q && out_ready && bundle_q.mem_ren && (bundle_q.reg_waddr != '0);

  // Output valid: flush kills the held bundle, a transfer refills it, a drain empties it.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
    end else if (flush) begin
      out_valid_q <= 1'b0;
    end else if (take) begin
      out_valid_q <= 1'b1;
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  // Bundle register: loads only on an accepted instruction so it holds under backpressure.
  always_ff @(posedge clk) begin
    if (rst) begin
      bundle_q             <= '0;
      bundle_q.imm_gen_op  <= IMM_GEN_I;
      bundle_q.alu_op      <= ALU_OP_WIDTH'(ALU_AND);
      bundle_q.alu_src_sel <= ALU_SRC_REG;
      out_pc_q             <= '0;
    end else if (take) begin
      bundle_q <= bundle_d;
      out_pc_q <= pc;
    end
  end

  // Load-use interlock: arm when a load with a real destination leaves, then count down.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= 2'd0;
      ld_rd_q     <= '0;
    end else if (flush) begin
      stall_cnt_q <= 2'd0;
    end else if (arm) begin
      stall_cnt_q <= STALL_INIT;
      ld_rd_q     <= bundle_q.reg_waddr;
    end else if (stall_cnt_q != 2'd0) begin
      stall_cnt_q <= stall_cnt_q - 2'd1;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_pc      = out_pc_q;
  assign branch      = bundle_q.branch;
  assign branch_cond = bundle_q.branch_cond;
  assign jump        = bundle_q.jump;
  assign jalr        = bundle_q.jalr;
  assign reg_wen     = bundle_q.reg_wen;
  assign reg_waddr   = bundle_q.reg_waddr;
  assign reg1_raddr  = bundle_q.reg1_raddr;
  assign reg2_raddr  = bundle_q.reg2_raddr;
  assign imm_gen_op  = bundle_q.imm_gen_op;
  assign alu_op      = bundle_q.alu_op;
  assign alu_src_sel = bundle_q.alu_src_sel;
  assign mem_ren     = bundle_q.mem_ren;
  assign mem_wen     = bundle_q.mem_wen;
  assign mem_size    = bundle_q.mem_size;
  assign illegal     = bundle_q.illegal;

endmodule

// File: tb/tb_ctrl_pipe.sv
// Bench for ctrl_pipe: directed literal checks followed by randomized
// traffic compared every cycle against a transaction-level model.
module tb_ctrl_pipe;

  localparam int LUS = 1;

  localparam logic [31:0] I_ADD  = 32'h002081B3;  // add x3,x1,x2
  localparam logic [31:0] I_SUB  = 32'h40208233;  // sub x4,x1,x2
  localparam logic [31:0] I_BAD  = 32'h02208233;  // funct7 0x01
  localparam logic [31:0] I_ONES = 32'hFFFFFFFF;
  localparam logic [31:0] I_BNE  = 32'h00209463;  // bne x1,x2
  localparam logic [31:0] I_LW5  = 32'h0000A283;  // lw x5,0(x1)
  localparam logic [31:0] I_LW0  = 32'h0000A003;  // lw x0,0(x1)
  localparam logic [31:0] I_ADD6 = 32'h00528333;  // add x6,x5,x5

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, flush, out_valid, out_ready;
  logic [31:0] inst, pc, out_pc;
  logic        branch, jump, jalr, reg_wen, mem_ren, mem_wen, illegal;
  logic [2:0]  branch_cond, imm_gen_op, mem_size;
  logic [4:0]  reg_waddr, reg1_raddr, reg2_raddr;
  logic [3:0]  alu_op;
  logic [1:0]  alu_src_sel;

  always #5 clk = ~clk;

  ctrl_pipe #(
    .CPU_WIDTH(32), .REG_ADDR_WIDTH(5), .ALU_OP_WIDTH(4), .LOAD_USE_STALL(LUS)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .inst(inst), .pc(pc),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .branch(branch), .branch_cond(branch_cond), .jump(jump), .jalr(jalr), .reg_wen(reg_wen),
    .reg_waddr(reg_waddr), .reg1_raddr(reg1_raddr), .reg2_raddr(reg2_raddr),
    .imm_gen_op(imm_gen_op), .alu_op(alu_op), .alu_src_sel(alu_src_sel),
    .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_size(mem_size), .illegal(illegal)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic        br;
    logic [2:0]  bc;
    logic        jmp, jr, wen;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  imm;
    logic [3:0]  alu;
    logic [1:0]  src;
    logic        mren, mwen;
    logic [2:0]  msz;
    logic        ill;
  } bun_t;

  int total = 0;
  int bad = 0;
  logic seen_rdy = 1'b0;
  logic [31:0] pc_ctr = 32'h1000;

  // model state: what the output register holds and the interlock status
  bit   m_valid = 1'b0;
  bun_t m_b = '0;
  int   m_stall = 0;
  int   m_ldrd = 0;

  task automatic chk(input string nm, input logic [95:0] got, input logic [95:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  // Reference decode straight from the RV32I encoding rules.
  function automatic void m_dec(input logic [31:0] i, output bun_t b, output bit u1, output bit u2);
    logic [2:0] f3;
    logic [6:0] f7;
    bit ok, w;
    int alu_tab [8];
    alu_tab = '{0, 2, 3, 4, 5, 6, 8, 9};
    f3 = i[14:12];
    f7 = i[31:25];
    b = '0; b.alu = 4'd9; ok = 1; w = 0; u1 = 0; u2 = 0;
    case (i[6:0])
      7'h33: begin
        ok = (f7 == 0) || (f7 == 7'h20 && (f3 == 0 || f3 == 5));
        b.alu = (f7 == 7'h20) ? ((f3 == 0) ? 4'd1 : 4'd7) : 4'(alu_tab[f3]);
        w = 1; u1 = 1; u2 = 1;
      end
      7'h13: begin
        ok = (f3 == 1) ? (f7 == 0) : (f3 == 5) ? (f7 == 0 || f7 == 7'h20) : 1'b1;
        b.alu = (f3 == 5 && f7 == 7'h20) ? 4'd7 : 4'(alu_tab[f3]);
        b.src = 1; w = 1; u1 = 1;
      end
      7'h03: begin
        ok = f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
        b.alu = 0; b.src = 1; b.mren = 1; b.msz = f3; w = 1; u1 = 1;
      end
      7'h23: begin
        ok = (f3 <= 2);
        b.imm = 1; b.alu = 0; b.src = 1; b.mwen = 1; b.msz = f3; u1 = 1; u2 = 1;
      end
      7'h63: begin
        ok = (f3 != 2 && f3 != 3);
        b.br = 1; b.bc = f3; b.imm = 2; b.alu = 1; u1 = 1; u2 = 1;
      end
      7'h6F: begin b.jmp = 1; b.imm = 4; b.alu = 0; b.src = 2; w = 1; end
      7'h67: begin ok = (f3 == 0); b.jmp = 1; b.jr = 1; b.alu = 0; b.src = 2; w = 1; u1 = 1; end
      7'h37: begin b.imm = 3; b.alu = 0; b.src = 1; w = 1; end
      7'h17: begin b.imm = 3; b.alu = 0; b.src = 3; w = 1; end
      default: ok = 0;
    endcase
    if (!ok) begin
      b = '0; b.alu = 4'd9; b.ill = 1; w = 0; u1 = 0; u2 = 0;
    end
    b.wen = w;
    b.rd  = w  ? i[11:7]  : 5'd0;
    b.rs1 = u1 ? i[19:15] : 5'd0;
    b.rs2 = u2 ? i[24:20] : 5'd0;
  endfunction

  function automatic bun_t dut_bun();
    bun_t b;
    b = {out_pc, branch, branch_cond, jump, jalr, reg_wen, reg_waddr, reg1_raddr, reg2_raddr,
         imm_gen_op, alu_op, alu_src_sel, mem_ren, mem_wen, mem_size, illegal};
    return b;
  endfunction

  // Compare against the model, then advance the model with the inputs the next edge will sample.
  always @(negedge clk) begin
    bun_t db;
    bit u1, u2, hz, rdy, issue_ld;
    seen_rdy = in_ready;
    chk("out_valid", 96'(out_valid), 96'(m_valid));
    if (m_valid) chk("bundle", 96'(dut_bun()), 96'(m_b));
    m_dec(inst, db, u1, u2);
    db.pc = pc;
    hz = (m_stall != 0) && in_valid &&
         ((u1 && inst[19:15] == m_ldrd) || (u2 && inst[24:20] == m_ldrd));
    rdy = (!m_valid || out_ready) && !hz && !flush;
    if (!rst) chk("in_ready", 96'(in_ready), 96'(rdy));
    if (rst) begin
      m_valid = 0; m_stall = 0; m_ldrd = 0; m_b = '0; m_b.alu = 4'd9;
    end else if (flush) begin
      m_valid = 0; m_stall = 0;
    end else begin
      issue_ld = m_valid && out_ready && m_b.mren && (m_b.rd != 0);
      if (issue_ld) begin
        m_stall = LUS; m_ldrd = m_b.rd;
      end else if (m_stall > 0) begin
        m_stall--;
      end
      if (in_valid && rdy) begin
        m_valid = 1; m_b = db;
      end else if (out_ready) begin
        m_valid = 0;
      end
    end
  end

  task automatic cyc(input logic r, input logic v, input logic [31:0] i, input logic fl, input logic ordy);
    rst = r; in_valid = v; inst = i; flush = fl; out_ready = ordy;
    pc = pc_ctr; pc_ctr += 32'd4;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rand_inst();
    logic [4:0] rd, r1, r2;
    logic [2:0] f3;
    logic [6:0] f7;
    rd = 5'($urandom_range(0, 7));
    r1 = 5'($urandom_range(0, 7));
    r2 = 5'($urandom_range(0, 7));
    f3 = 3'($urandom_range(0, 7));
    case ($urandom_range(0, 3))
      0, 1:    f7 = 7'h00;
      2:       f7 = 7'h20;
      default: f7 = 7'($urandom);
    endcase
    case ($urandom_range(0, 11))
      0, 10:   return {f7, r2, r1, f3, rd, 7'h33};
      1:       return {f7, r2, r1, f3, rd, 7'h13};
      2, 11:   return {7'($urandom), r2, r1, f3, rd, 7'h03};
      3:       return {7'($urandom), r2, r1, f3, rd, 7'h23};
      4:       return {7'($urandom), r2, r1, f3, rd, 7'h63};
      5:       return {20'($urandom), rd, 7'h6F};
      6:       return {7'($urandom), r2, r1, ($urandom_range(0, 1) != 0) ? 3'd0 : f3, rd, 7'h67};
      7:       return {20'($urandom), rd, 7'h37};
      8:       return {20'($urandom), rd, 7'h17};
      default: return $urandom;
    endcase
  endfunction

  initial begin
    rst = 1; in_valid = 1; inst = I_ADD; pc = 0; flush = 0; out_ready = 1;
    // reset with an instruction offered: nothing captured
    cyc(1, 1, I_ADD, 0, 1);
    chk("rst_ov0", 96'(out_valid), 96'd0);
    cyc(1, 1, I_ADD, 0, 1);
    chk("rst_ov1", 96'(out_valid), 96'd0);
    chk("rst_vals", 96'({imm_gen_op, alu_op, alu_src_sel, reg_wen, mem_ren, mem_wen, illegal}),
        96'({3'd0, 4'd9, 2'd0, 4'b0000}));
    cyc(0, 0, I_ADD, 0, 1);
    chk("post_rst_rdy", 96'(seen_rdy), 96'd1);
    // decode literals
    cyc(0, 1, I_ADD, 0, 1);
    chk("add_fields", 96'({out_valid, alu_op, reg_waddr, reg1_raddr, reg2_raddr, reg_wen}),
        96'({1'b1, 4'd0, 5'd3, 5'd1, 5'd2, 1'b1}));
    cyc(0, 1, I_SUB, 0, 1);
    chk("sub_alu", 96'(alu_op), 96'd1);
    cyc(0, 1, I_BAD, 0, 1);
    chk("badf7_ill", 96'({illegal, reg_wen}), 96'(2'b10));
    cyc(0, 1, I_ONES, 0, 1);
    chk("ones_ill", 96'({illegal, reg_wen, mem_ren, mem_wen, branch, jump}), 96'(6'b100000));
    cyc(0, 1, I_BNE, 0, 1);
    chk("bne", 96'({branch, branch_cond, imm_gen_op}), 96'({1'b1, 3'b001, 3'd2}));
    cyc(0, 0, I_ADD, 0, 1);
    // load-use bubble
    cyc(0, 1, I_LW5, 0, 1);
    chk("lw_acc", 96'({seen_rdy, mem_ren, reg_waddr}), 96'({1'b1, 1'b1, 5'd5}));
    cyc(0, 0, I_ADD, 0, 1);
    cyc(0, 1, I_ADD6, 0, 1);
    chk("lu_bubble", 96'(seen_rdy), 96'd0);
    cyc(0, 1, I_ADD6, 0, 1);
    chk("lu_after", 96'({seen_rdy, reg_waddr}), 96'({1'b1, 5'd6}));
    // load to x0 arms nothing
    cyc(0, 1, I_LW0, 0, 1);
    cyc(0, 0, I_ADD, 0, 1);
    cyc(0, 1, I_ADD6, 0, 1);
    chk("lw_x0_nobub", 96'(seen_rdy), 96'd1);
    cyc(0, 0, I_ADD, 0, 1);
    // backpressure hold
    cyc(0, 1, I_ADD, 0, 0);
    chk("bp_acc", 96'(seen_rdy), 96'd1);
    for (int k = 0; k < 3; k++) begin
      cyc(0, 1, I_SUB, 0, 0);
      chk("bp_hold", 96'({seen_rdy, out_valid, alu_op, reg_waddr}), 96'({1'b0, 1'b1, 4'd0, 5'd3}));
    end
    cyc(0, 1, I_SUB, 0, 1);
    chk("bp_release", 96'({seen_rdy, alu_op}), 96'({1'b1, 4'd1}));
    // flush with a pending load stall
    cyc(0, 0, I_ADD, 0, 1);
    cyc(0, 1, I_LW5, 0, 1);
    cyc(0, 0, I_ADD, 0, 1);
    cyc(0, 1, I_ADD6, 1, 1);
    chk("flush_drop", 96'({seen_rdy, out_valid}), 96'(2'b00));
    cyc(0, 1, I_ADD6, 0, 1);
    chk("flush_clr", 96'({seen_rdy, out_valid, reg_waddr}), 96'({1'b1, 1'b1, 5'd6}));
    cyc(0, 0, I_ADD, 0, 1);
    // randomized traffic, checked by the model every cycle
    for (int n = 0; n < 4000; n++) begin
      cyc($urandom_range(0, 599) == 0, $urandom_range(0, 9) < 7, rand_inst(),
          $urandom_range(0, 19) == 0, $urandom_range(0, 9) < 7);
    end
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
